// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Oversamples an asynchronous serial line,
//               deserialises LSB-first frames (start, N data, optional even
//               parity, one stop) and reports each good word with a
//               one-cycle valid strobe. Parity and framing errors are
//               reported as one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int N       = 8,
    parameter int PSCALER = 1,
    parameter int DIV     = 10
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         parity_i,
    input  logic         rx_i,
    output logic [N-1:0] rx_data_o,
    output logic         rx_valid_o,
    output logic         parity_err_o,
    output logic         frame_err_o,
    output logic         rx_busy_o
);

    // Bit timing is counted directly in sysclk cycles so the half-bit point
    // lands on floor(T/2) even when that is not a whole number of prescaler
    // ticks; the resulting bit period is identical to uart_tx.
    localparam int C_BIT_T  = PSCALER * DIV;
    localparam int C_HALF_T = C_BIT_T / 2;
    localparam int C_CW     = $clog2(C_BIT_T);
    localparam int C_BW     = $clog2(N);

    localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(C_HALF_T - 1);
    localparam logic [C_CW-1:0] C_BIT_LAST  = C_CW'(C_BIT_T - 1);
    localparam logic [C_BW-1:0] C_DATA_LAST = C_BW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t            state_q,      state_d;
    logic              sync1_q,      sync2_q,  sync3_q;
    logic [C_CW-1:0]   cnt_q,        cnt_d;
    logic [C_BW-1:0]   bit_q,        bit_d;
    logic [N-1:0]      shift_q,      shift_d;
    logic [N-1:0]      data_q,       data_d;
    logic              par_en_q,     par_en_d;
    logic              par_acc_q,    par_acc_d;
    logic              perr_q,       perr_d;
    logic              valid_q,      valid_d;
    logic              perr_pulse_q, perr_pulse_d;
    logic              ferr_q,       ferr_d;

    logic              w_fall;
    logic              w_bit_end;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Receiver state, timing counters, shift register and result registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_acc_q    <= 1'b0;
            perr_q       <= 1'b0;
            valid_q      <= 1'b0;
            perr_pulse_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_acc_q    <= par_acc_d;
            perr_q       <= perr_d;
            valid_q      <= valid_d;
            perr_pulse_q <= perr_pulse_d;
            ferr_q       <= ferr_d;
        end
    end

    // Next-state logic: mid-bit sampling, deserialisation and result decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_acc_d    = par_acc_q;
        perr_d       = perr_q;
        valid_d      = 1'b0;
        perr_pulse_d = 1'b0;
        ferr_d       = 1'b0;

        w_fall    = sync3_q & ~sync2_q;
        w_bit_end = (cnt_q == C_BIT_LAST);

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_en_d  = parity_i;
                    par_acc_d = 1'b0;
                    perr_d    = 1'b0;
                end
            end

            S_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    // A line already back high at mid-start is a glitch
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[N-1:1]};
                    par_acc_d = par_acc_q ^ sync2_q;
                    if (bit_q == C_DATA_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    // Even parity: XOR over data and parity bit must be zero
                    perr_d  = par_acc_q ^ sync2_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        if (perr_q) begin
                            perr_pulse_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d       = 1'b1;
                        perr_pulse_d = perr_q;
                        state_d      = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                // Hold off new starts until a break / stuck-low line releases
                if (sync2_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_pulse_q;
    assign frame_err_o  = ferr_q;
    assign rx_busy_o    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are driven onto rx_i
//               bit by bit; a frame-level reference model predicts every
//               result pulse (kind, cycle, data) and the final rx_data_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C_N       = 8;
    localparam int C_PSCALER = 1;
    localparam int C_DIV     = 10;
    localparam int C_T       = C_PSCALER * C_DIV;
    localparam int C_HALF    = C_T / 2;

    logic           sysclk   = 1'b0;
    logic           reset_n  = 1'b0;
    logic           parity_i = 1'b0;
    logic           rx_i     = 1'b1;
    logic [C_N-1:0] rx_data_o;
    logic           rx_valid_o;
    logic           parity_err_o;
    logic           frame_err_o;
    logic           rx_busy_o;

    // kind: 0 = valid, 1 = parity error, 2 = frame error
    typedef struct packed {
        logic [31:0] t;
        logic [1:0]  kind;
        logic [7:0]  data;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        exp_q[$];
    logic       busy_hist [int];
    int         cyc          = 0;
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] last_good    = 8'h00;

    uart_rx #(
        .N       (C_N),
        .PSCALER (C_PSCALER),
        .DIV     (C_DIV)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .parity_i     (parity_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .rx_busy_o    (rx_busy_o)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Record every output pulse and the busy flag, 1 time unit after each edge
    always @(posedge sysclk) begin
        #1;
        busy_hist[cyc] = rx_busy_o;
        if (rx_valid_o)   ev_q.push_back({32'(cyc), 2'd0, rx_data_o});
        if (parity_err_o) ev_q.push_back({32'(cyc), 2'd1, 8'h00});
        if (frame_err_o)  ev_q.push_back({32'(cyc), 2'd2, 8'h00});
    end

    // Frame-level reference: outcome from the ones count and stop bit,
    // pulse time from the bit-period arithmetic.
    function automatic void model_frame(input int e0, input logic [7:0] d,
                                        input bit pen, input bit pbit, input bit stop);
        int ones;
        bit perr;
        int t;
        ones = $countones(d) + ((pen && pbit) ? 1 : 0);
        perr = pen && ((ones % 2) != 0);
        t    = e0 + 2 + C_HALF + (C_N + (pen ? 1 : 0) + 1) * C_T;
        if (stop && !perr) begin
            exp_q.push_back({32'(t), 2'd0, d});
            last_good = d;
        end else begin
            if (perr)  exp_q.push_back({32'(t), 2'd1, 8'h00});
            if (!stop) exp_q.push_back({32'(t), 2'd2, 8'h00});
        end
    endfunction

    // Must be called at a negedge; returns at a negedge with the line high.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit stop, input int extra_low, output int e0);
        parity_i = pen;
        rx_i     = 1'b0;
        e0       = cyc + 1;
        repeat (C_T) @(negedge sysclk);
        for (int i = 0; i < C_N; i++) begin
            rx_i = d[i];
            repeat (C_T) @(negedge sysclk);
        end
        if (pen) begin
            rx_i = pbit;
            repeat (C_T) @(negedge sysclk);
        end
        rx_i = stop;
        repeat (C_T + extra_low) @(negedge sysclk);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        tests_run++;
        if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_held: outputs=%h expected=000",
                     {rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge sysclk);
        tests_run++;
        if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_idle: outputs=%h expected=000",
                     {rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o});
        end
    endtask

    task automatic test_single();
        int e0;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, e0);
        model_frame(e0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge sysclk);
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL single_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL single_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
        tests_run++;
        if (busy_hist[e0 + 96] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy96: got %b expected 1", busy_hist[e0 + 96]);
        end
        tests_run++;
        if (busy_hist[e0 + 98] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy98: got %b expected 0", busy_hist[e0 + 98]);
        end
        tests_run++;
        if (rx_data_o !== last_good) begin
            tests_failed++;
            $display("FAIL single_data: got %h expected %h", rx_data_o, last_good);
        end
    endtask

    task automatic test_back_to_back();
        int e0a, e0b;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 0, e0a);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 0, e0b);
        model_frame(e0a, 8'hA3, 1'b0, 1'b0, 1'b1);
        model_frame(e0b, 8'h0F, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge sysclk);
        tests_run++;
        if (e0b - e0a !== 100) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d expected 100", e0b - e0a);
        end
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_parity();
        int e0a, e0b;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0, e0a);
        model_frame(e0a, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge sysclk);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, e0b);
        model_frame(e0b, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge sysclk);
        parity_i = 1'b0;
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL parity_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL parity_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
        tests_run++;
        if (rx_data_o !== 8'h07) begin
            tests_failed++;
            $display("FAIL parity_data: got %h expected 07", rx_data_o);
        end
    endtask

    task automatic test_frame_err();
        int e0a, e0b;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 30, e0a);
        model_frame(e0a, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge sysclk);
        tests_run++;
        if (rx_data_o !== last_good) begin
            tests_failed++;
            $display("FAIL ferr_data: got %h expected %h", rx_data_o, last_good);
        end
        tests_run++;
        if (busy_hist[e0a + 125] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_busy_low_line: got %b expected 1", busy_hist[e0a + 125]);
        end
        tests_run++;
        if (busy_hist[e0a + 135] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_busy_released: got %b expected 0", busy_hist[e0a + 135]);
        end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, e0b);
        model_frame(e0b, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge sysclk);
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL ferr_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL ferr_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_glitch();
        int e0;
        ev_q.delete();
        @(negedge sysclk);
        rx_i = 1'b0;
        e0   = cyc + 1;
        repeat (3) @(negedge sysclk);
        rx_i = 1'b1;
        repeat (15) @(negedge sysclk);
        tests_run++;
        if (busy_hist[e0 + 2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_busy_start: got %b expected 1", busy_hist[e0 + 2]);
        end
        tests_run++;
        if (busy_hist[e0 + 8] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy_abort: got %b expected 0", busy_hist[e0 + 8]);
        end
        tests_run++;
        if (ev_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: got %0d pulses expected 0", ev_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int e0a, e0b;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        fork
            send_frame(8'h99, 1'b0, 1'b0, 1'b1, 0, e0a);
            begin
                repeat (40) @(negedge sysclk);
                tests_run++;
                if (rx_busy_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rstmid_busy_before: got %b expected 1", rx_busy_o);
                end
                #2 reset_n = 1'b0;
                #1;
                tests_run++;
                if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o} !== 12'h000) begin
                    tests_failed++;
                    $display("FAIL rstmid_outputs: got %h expected 000",
                             {rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o});
                end
            end
        join
        reset_n   = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge sysclk);
        send_frame(8'hC6, 1'b0, 1'b0, 1'b1, 0, e0b);
        model_frame(e0b, 8'hC6, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge sysclk);
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL rstmid_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rstmid_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        int         e0;
        logic [7:0] d;
        bit         pen, pbit, stop;
        int         extra, gap;
        ev_q.delete(); exp_q.delete();
        @(negedge sysclk);
        for (int k = 0; k < 12; k++) begin
            d     = 8'($urandom);
            pen   = 1'($urandom_range(0, 1));
            pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 4) != 0);
            extra = stop ? 0 : int'($urandom_range(0, 20));
            gap   = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            send_frame(d, pen, pbit, stop, extra, e0);
            model_frame(e0, d, pen, pbit, stop);
            repeat (gap) @(negedge sysclk);
        end
        repeat (20) @(negedge sysclk);
        parity_i = 1'b0;
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            tests_run++;
            if (ev_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_ev%0d: got t=%0d k=%0d d=%h expected t=%0d k=%0d d=%h", i,
                         ev_q[i].t, ev_q[i].kind, ev_q[i].data, exp_q[i].t, exp_q[i].kind, exp_q[i].data);
            end
        end
        tests_run++;
        if (rx_data_o !== last_good) begin
            tests_failed++;
            $display("FAIL rand_data: got %h expected %h", rx_data_o, last_good);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
